// File: rtl/inta_sequencer.sv
// 8086-mode interrupt-acknowledge sequencer: tracks the two INTA_N pulses, latches the
// winning level, pulses ISR set bits, drives cascade code as master and the vector on INTA #2.
module inta_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       INTA_N,
  input  logic       INT_REQ,
  input  logic [2:0] HIGHEST_IR,
  input  logic       SNGL,
  input  logic       Master_Slave,
  input  logic [2:0] ID,
  input  logic [7:0] SLAVE_MASK,
  input  logic [2:0] SLAVE_ID,
  input  logic [4:0] VECTOR_BASE,
  input  logic       AEOI,
  output logic [7:0] ISR_SET,
  output logic [2:0] CAS_CODE,
  output logic       CAS_EN,
  output logic [7:0] DATA_OUT,
  output logic       DATA_EN,
  output logic       EOI_PULSE,
  output logic [2:0] EOI_LEVEL,
  output logic       TIMEOUT_ERR
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} state_t;

  state_t          state_q, state_d;
  logic            inta_q, inta_d;
  logic [2:0]      level_q, level_d;
  logic            spurious_q, spurious_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic [7:0]      isr_set_q, isr_set_d;
  logic [2:0]      cas_code_q, cas_code_d;
  logic            cas_en_q, cas_en_d;
  logic [7:0]      data_out_q, data_out_d;
  logic            data_en_q, data_en_d;
  logic            eoi_pulse_q, eoi_pulse_d;
  logic [2:0]      eoi_level_q, eoi_level_d;
  logic            timeout_err_q, timeout_err_d;

  logic            fall, rise, own, slave_mode, timer_done;

  function automatic logic [7:0] onehot(input logic [2:0] n);
    return 8'h01 << n;
  endfunction

  // Master broadcasts the level on CAS only when a slave hangs off that IR input.
  function automatic logic cas_active(input logic [2:0] lvl);
    return ~SNGL & Master_Slave & SLAVE_MASK[lvl];
  endfunction

  assign fall       = inta_q & ~INTA_N;
  assign rise       = ~inta_q & INTA_N;
  assign slave_mode = ~SNGL & ~Master_Slave;
  assign timer_done = (timer_q == TW'(TIMEOUT - 1));
  assign own        = SNGL
                    | (Master_Slave & ~SLAVE_MASK[level_q])
                    | (~Master_Slave & (ID == SLAVE_ID));

  always_comb begin
    state_d       = state_q;
    inta_d        = INTA_N;
    level_d       = level_q;
    spurious_d    = spurious_q;
    timer_d       = timer_q;
    isr_set_d     = 8'h00;
    cas_code_d    = 3'd0;
    cas_en_d      = 1'b0;
    data_out_d    = 8'h00;
    data_en_d     = 1'b0;
    eoi_pulse_d   = 1'b0;
    eoi_level_d   = 3'd0;
    timeout_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d    = ACK1;
          level_d    = INT_REQ ? HIGHEST_IR : 3'd7;
          spurious_d = ~INT_REQ;
          if (INT_REQ & (SNGL | Master_Slave))
            isr_set_d = onehot(HIGHEST_IR);
        end
      end
      ACK1: begin
        if (rise) begin
          state_d = WAIT2;
          timer_d = '0;
        end
      end
      WAIT2: begin
        timer_d = timer_q + 1'b1;
        // A fall on the terminal count still completes the acknowledge.
        if (fall) begin
          state_d    = ACK2;
          data_en_d  = own;
          data_out_d = {VECTOR_BASE, level_q};
          if (slave_mode & own & ~spurious_q)
            isr_set_d = onehot(level_q);
        end else if (timer_done) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
        end
      end
      ACK2: begin
        if (rise) begin
          state_d = IDLE;
          if (AEOI & own & ~spurious_q) begin
            eoi_pulse_d = 1'b1;
            eoi_level_d = level_q;
          end
        end else begin
          data_en_d  = own;
          data_out_d = {VECTOR_BASE, level_q};
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_d != IDLE) && cas_active(level_d)) begin
      cas_en_d   = 1'b1;
      cas_code_d = level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      inta_q        <= 1'b1;
      level_q       <= 3'd0;
      spurious_q    <= 1'b0;
      timer_q       <= '0;
      isr_set_q     <= 8'h00;
      cas_code_q    <= 3'd0;
      cas_en_q      <= 1'b0;
      data_out_q    <= 8'h00;
      data_en_q     <= 1'b0;
      eoi_pulse_q   <= 1'b0;
      eoi_level_q   <= 3'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      inta_q        <= inta_d;
      level_q       <= level_d;
      spurious_q    <= spurious_d;
      timer_q       <= timer_d;
      isr_set_q     <= isr_set_d;
      cas_code_q    <= cas_code_d;
      cas_en_q      <= cas_en_d;
      data_out_q    <= data_out_d;
      data_en_q     <= data_en_d;
      eoi_pulse_q   <= eoi_pulse_d;
      eoi_level_q   <= eoi_level_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign ISR_SET     = isr_set_q;
  assign CAS_CODE    = cas_code_q;
  assign CAS_EN      = cas_en_q;
  assign DATA_OUT    = data_out_q;
  assign DATA_EN     = data_en_q;
  assign EOI_PULSE   = eoi_pulse_q;
  assign EOI_LEVEL   = eoi_level_q;
  assign TIMEOUT_ERR = timeout_err_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: directed and randomized INTA sequences checked against
// expectations derived from the acknowledge rules (ownership, vector, cascade, EOI, timeout).
module tb_inta_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       INTA_N;
  logic       INT_REQ;
  logic [2:0] HIGHEST_IR;
  logic       SNGL;
  logic       Master_Slave;
  logic [2:0] ID;
  logic [7:0] SLAVE_MASK;
  logic [2:0] SLAVE_ID;
  logic [4:0] VECTOR_BASE;
  logic       AEOI;
  logic [7:0] ISR_SET;
  logic [2:0] CAS_CODE;
  logic       CAS_EN;
  logic [7:0] DATA_OUT;
  logic       DATA_EN;
  logic       EOI_PULSE;
  logic [2:0] EOI_LEVEL;
  logic       TIMEOUT_ERR;

  int tests = 0;
  int fails = 0;

  inta_sequencer #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .INTA_N(INTA_N), .INT_REQ(INT_REQ),
    .HIGHEST_IR(HIGHEST_IR), .SNGL(SNGL), .Master_Slave(Master_Slave), .ID(ID),
    .SLAVE_MASK(SLAVE_MASK), .SLAVE_ID(SLAVE_ID), .VECTOR_BASE(VECTOR_BASE), .AEOI(AEOI),
    .ISR_SET(ISR_SET), .CAS_CODE(CAS_CODE), .CAS_EN(CAS_EN), .DATA_OUT(DATA_OUT),
    .DATA_EN(DATA_EN), .EOI_PULSE(EOI_PULSE), .EOI_LEVEL(EOI_LEVEL), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic configure(input logic sngl, input logic ms, input logic [7:0] mask,
                           input logic [2:0] sid, input logic [2:0] id,
                           input logic [4:0] base, input logic aeoi);
    SNGL = sngl; Master_Slave = ms; SLAVE_MASK = mask; SLAVE_ID = sid; ID = id;
    VECTOR_BASE = base; AEOI = aeoi;
  endtask

  // Full two-pulse acknowledge; expectations come from the acknowledge rules directly.
  task automatic run_seq(input logic req, input logic [2:0] ir,
                         input int low1, input int gap, input int low2);
    logic [2:0] lvl;
    logic       own, cas_on, slave;
    logic [7:0] isr1, isr2, vec;
    lvl    = req ? ir : 3'd7;
    slave  = ~SNGL & ~Master_Slave;
    own    = SNGL | (Master_Slave & ~SLAVE_MASK[lvl]) | (~Master_Slave & (ID == SLAVE_ID));
    cas_on = ~SNGL & Master_Slave & SLAVE_MASK[lvl];
    isr1   = (req & (SNGL | Master_Slave)) ? (8'h01 << ir) : 8'h00;
    isr2   = (slave & own & req) ? (8'h01 << lvl) : 8'h00;
    vec    = {VECTOR_BASE, lvl};

    INT_REQ = req; HIGHEST_IR = ir; INTA_N = 1'b1;
    tick(); tick();
    INTA_N = 1'b0;
    tick();
    chk("isr_first_fall", ISR_SET, isr1);
    chk("cas_en_ack1", CAS_EN, cas_on);
    chk("cas_code_ack1", CAS_CODE, cas_on ? lvl : 3'd0);
    chk("data_en_ack1", DATA_EN, 1'b0);
    // Priority inputs move after the first fall; the latched level must not.
    INT_REQ = 1'($urandom); HIGHEST_IR = 3'($urandom);
    for (int i = 1; i < low1; i++) begin
      tick();
      chk("isr_ack1_hold", ISR_SET, 8'h00);
    end
    INTA_N = 1'b1;
    tick();
    chk("isr_wait2", ISR_SET, 8'h00);
    chk("cas_en_wait2", CAS_EN, cas_on);
    for (int i = 0; i < gap; i++) begin
      tick();
      chk("timeout_gap", TIMEOUT_ERR, 1'b0);
    end
    INTA_N = 1'b0;
    tick();
    chk("isr_second_fall", ISR_SET, isr2);
    chk("data_en_ack2", DATA_EN, own);
    chk("data_out_ack2", DATA_OUT, vec);
    chk("timeout_ack2", TIMEOUT_ERR, 1'b0);
    chk("cas_code_ack2", CAS_CODE, cas_on ? lvl : 3'd0);
    for (int i = 1; i < low2; i++) begin
      tick();
      chk("data_en_ack2_hold", DATA_EN, own);
      chk("isr_ack2_hold", ISR_SET, 8'h00);
    end
    INTA_N = 1'b1;
    tick();
    chk("data_en_after_rise", DATA_EN, 1'b0);
    chk("cas_en_after_rise", CAS_EN, 1'b0);
    chk("eoi_pulse", EOI_PULSE, AEOI & own & req);
    chk("eoi_level", EOI_LEVEL, (AEOI & own & req) ? lvl : 3'd0);
    tick();
    chk("eoi_pulse_end", EOI_PULSE, 1'b0);
  endtask

  initial begin
    logic [2:0] r_ir;
    logic       r_sngl, r_ms;
    logic [2:0] r_sid;

    reset = 1'b1; INTA_N = 1'b1; INT_REQ = 1'b0; HIGHEST_IR = 3'd0;
    configure(1'b1, 1'b1, 8'h00, 3'd0, 3'd0, 5'h00, 1'b0);
    tick(); tick();
    chk("reset_outputs", {ISR_SET, CAS_CODE, CAS_EN, DATA_OUT, DATA_EN, EOI_PULSE,
                          EOI_LEVEL, TIMEOUT_ERR}, 32'h0);
    reset = 1'b0;
    tick();

    // Single PIC, IR5, base 08
    configure(1'b1, 1'b1, 8'h00, 3'd0, 3'd0, 5'h08, 1'b0);
    run_seq(1'b1, 3'd5, 2, 3, 2);
    // Master with slave on IR3
    configure(1'b0, 1'b1, 8'h08, 3'd0, 3'd0, 5'h08, 1'b0);
    run_seq(1'b1, 3'd3, 1, 2, 1);
    // Slave, ID matches, then mismatches
    configure(1'b0, 1'b0, 8'h00, 3'd2, 3'd2, 5'h10, 1'b0);
    run_seq(1'b1, 3'd1, 2, 1, 2);
    configure(1'b0, 1'b0, 8'h00, 3'd2, 3'd6, 5'h10, 1'b1);
    run_seq(1'b1, 3'd1, 2, 1, 2);
    // Spurious with auto-EOI enabled
    configure(1'b1, 1'b1, 8'h00, 3'd0, 3'd0, 5'h08, 1'b1);
    run_seq(1'b0, 3'd2, 1, 1, 1);
    // Auto-EOI on IR4
    configure(1'b1, 1'b1, 8'h00, 3'd0, 3'd0, 5'h08, 1'b1);
    run_seq(1'b1, 3'd4, 1, 1, 1);
    // Second fall exactly on the terminal timeout cycle
    configure(1'b0, 1'b1, 8'h10, 3'd0, 3'd0, 5'h1F, 1'b1);
    run_seq(1'b1, 3'd4, 1, 15, 1);

    // Timeout: master with cascade active, no second INTA
    configure(1'b0, 1'b1, 8'hFF, 3'd0, 3'd0, 5'h03, 1'b0);
    INT_REQ = 1'b1; HIGHEST_IR = 3'd6; INTA_N = 1'b0;
    tick();
    chk("to_isr", ISR_SET, 8'h40);
    INTA_N = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("to_early", TIMEOUT_ERR, 1'b0);
      chk("to_cas_held", CAS_EN, 1'b1);
    end
    tick();
    chk("to_pulse", TIMEOUT_ERR, 1'b1);
    chk("to_cas_drop", CAS_EN, 1'b0);
    tick();
    chk("to_pulse_end", TIMEOUT_ERR, 1'b0);
    chk("to_no_rollback", ISR_SET, 8'h00);
    configure(1'b1, 1'b1, 8'h00, 3'd0, 3'd0, 5'h08, 1'b0);
    run_seq(1'b1, 3'd0, 1, 0, 1);

    // Reset asserted during ACK2
    configure(1'b1, 1'b1, 8'h00, 3'd0, 3'd0, 5'h08, 1'b1);
    INT_REQ = 1'b1; HIGHEST_IR = 3'd2; INTA_N = 1'b0;
    tick();
    INTA_N = 1'b1;
    tick();
    INTA_N = 1'b0;
    tick();
    chk("rst_pre_data_en", DATA_EN, 1'b1);
    reset = 1'b1; INTA_N = 1'b1;
    tick();
    chk("rst_mid_outputs", {ISR_SET, CAS_CODE, CAS_EN, DATA_OUT, DATA_EN, EOI_PULSE,
                            EOI_LEVEL, TIMEOUT_ERR}, 32'h0);
    reset = 1'b0;
    tick();
    chk("rst_after_outputs", {ISR_SET, CAS_CODE, CAS_EN, DATA_OUT, DATA_EN, EOI_PULSE,
                              EOI_LEVEL, TIMEOUT_ERR}, 32'h0);

    // Randomized sequences across all modes
    for (int n = 0; n < 40; n++) begin
      r_sngl = 1'($urandom);
      r_ms   = r_sngl ? 1'b1 : 1'($urandom);
      r_sid  = 3'($urandom);
      r_ir   = 3'($urandom);
      configure(r_sngl, r_ms, 8'($urandom), r_sid,
                ($urandom_range(0, 1) == 0) ? r_sid : 3'($urandom),
                5'($urandom), 1'($urandom));
      run_seq(($urandom_range(0, 3) != 0), r_ir, $urandom_range(1, 3),
              $urandom_range(0, 15), $urandom_range(1, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
